// File: rtl/qea_pkg.sv
// Shared definitions for the QEA host sequencer: FSM encoding, default
// geometry, fixed-point one and lane slicing helpers.
// Purely declarative; no logic, no latency, no backpressure.
package qea_pkg;

   localparam int QEA_PE_NUM            = 4;
   localparam int QEA_DATA_WIDTH        = 32;
   localparam int QEA_STATE_ADDR_WIDTH  = 16;
   localparam int QEA_CTX_ADDR_WIDTH    = 16;
   localparam int QEA_MAX_QBIT_WIDTH    = 6;
   localparam int QEA_NUM_FRAC_BIT      = 30;
   localparam int QEA_READ_LATENCY      = 1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD_CTX,
      ST_LOAD_STATE,
      ST_START,
      ST_RUN,
      ST_RD_ADDR,
      ST_RD_WAIT,
      ST_RD_OUT,
      ST_DONE
   } seq_state_t;

   // Fixed-point 1.0 with the given number of fraction bits (caller truncates).
   function automatic logic [63:0] fx_one(input int frac_bits);
      return 64'd1 << frac_bits;
   endfunction

   // Bit offset of a lane inside a packed multi-lane state word.
   function automatic int lane_lsb(input int lane, input int lane_width);
      return lane * lane_width;
   endfunction

endpackage

// File: rtl/qea_rd_capture.sv
// Readback capture: delays the read strobe by READ_LATENCY and holds the RAM word.
// Latency: captures READ_LATENCY cycles after issue; o_rd_valid the cycle after capture.
// Backpressure: word held stable with valid high until i_rd_ready; one word in flight.
//
// Ports: issue (read address on the RAM port this cycle), ram_dout (RAM data),
//        cap (RAM data is valid this cycle), rd_valid/rd_data/rd_ready (host stream).
module qea_rd_capture #(
   parameter int WIDTH        = 256,
   parameter int READ_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue,
   input  logic [WIDTH-1:0] ram_dout,
   output logic             cap,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   input  logic             rd_ready
);

   logic [READ_LATENCY-1:0] pipe;

   assign cap = pipe[READ_LATENCY-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe     <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         pipe[0] <= issue;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
         if (cap) begin
            rd_valid <= 1'b1;
            rd_data  <= ram_dout;
         end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/qea_host_sequencer.sv
// Host sequencer for QEA: loads context + |0..0> state, starts, times, reads state back.
// Latency: ctx write 1 cycle after handshake; readback word READ_LATENCY+1 after address.
// Backpressure: o_ctx_ready high only while loading; readback stalls on i_rd_ready low.
//
// Ports: i_go/i_qbit_num/i_ins_num job request; i_ctx_* host context stream;
//        o_qea_* and i_qea_* connect to the QEA ctx/state/start/complete port set;
//        o_rd_* readback stream; o_busy, o_exec_cycles, o_done job status.
module qea_host_sequencer
   import qea_pkg::*;
#(
   parameter int PE_NUM                  = QEA_PE_NUM,
   parameter int DATA_WIDTH              = QEA_DATA_WIDTH,
   parameter int STATE_DATA_WIDTH        = DATA_WIDTH * 2,
   parameter int STATE_ADDR_WIDTH        = QEA_STATE_ADDR_WIDTH,
   parameter int GATE_CONTEXT_DATA_WIDTH = DATA_WIDTH * 2,
   parameter int GATE_CONTEXT_ADDR_WIDTH = QEA_CTX_ADDR_WIDTH,
   parameter int MAX_QBIT_WIDTH          = QEA_MAX_QBIT_WIDTH,
   parameter int NUM_FRAC_BIT            = QEA_NUM_FRAC_BIT,
   parameter int READ_LATENCY            = QEA_READ_LATENCY
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  i_go,
   input  logic [MAX_QBIT_WIDTH-1:0]             i_qbit_num,
   input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]    i_ins_num,
   input  logic                                  i_ctx_valid,
   input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]    i_ctx_data,
   output logic                                  o_ctx_ready,
   output logic                                  o_qea_start,
   output logic [MAX_QBIT_WIDTH-1:0]             o_qea_qbit_num,
   output logic                                  o_qea_ctx_en,
   output logic                                  o_qea_ctx_wea,
   output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]    o_qea_ctx_addr,
   output logic [GATE_CONTEXT_DATA_WIDTH-1:0]    o_qea_ctx_data,
   output logic [PE_NUM-1:0]                     o_qea_state_ena,
   output logic [PE_NUM-1:0]                     o_qea_state_wea,
   output logic [STATE_ADDR_WIDTH-1:0]           o_qea_state_addr,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]    o_qea_state_din,
   input  logic                                  i_qea_complete,
   input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]    i_qea_state_dout,
   output logic                                  o_rd_valid,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]    o_rd_data,
   input  logic                                  i_rd_ready,
   output logic                                  o_busy,
   output logic [31:0]                           o_exec_cycles,
   output logic                                  o_done
);

   localparam int SW = PE_NUM * STATE_DATA_WIDTH;
   localparam logic [DATA_WIDTH-1:0] ONE_RE  = DATA_WIDTH'(fx_one(NUM_FRAC_BIT));
   localparam int                    TOP_LSB = lane_lsb(PE_NUM - 1, STATE_DATA_WIDTH);
   // |0..0>: amplitude 1.0 + 0i in the top lane of address 0, zero elsewhere.
   localparam logic [SW-1:0] INIT_WORD =
      SW'({ONE_RE, {DATA_WIDTH{1'b0}}}) << TOP_LSB;
   localparam logic [GATE_CONTEXT_ADDR_WIDTH-1:0] CTX_INC = GATE_CONTEXT_ADDR_WIDTH'(1);
   localparam logic [STATE_ADDR_WIDTH-1:0]        ST_INC  = STATE_ADDR_WIDTH'(1);

   seq_state_t                         state;
   logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_cnt;
   logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_last;
   logic [STATE_ADDR_WIDTH-1:0]        state_last;
   logic                               rd_issue;
   logic                               rd_cap;

   // The read address is on the QEA port for exactly the RD_ADDR cycle.
   assign rd_issue = (state == ST_RD_ADDR);

   qea_rd_capture #(
      .WIDTH        (SW),
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_capture (
      .clk      (clk),
      .rst      (rst),
      .issue    (rd_issue),
      .ram_dout (i_qea_state_dout),
      .cap      (rd_cap),
      .rd_valid (o_rd_valid),
      .rd_data  (o_rd_data),
      .rd_ready (i_rd_ready)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         ctx_cnt          <= '0;
         ins_last         <= '0;
         state_last       <= '0;
         o_ctx_ready      <= 1'b0;
         o_qea_start      <= 1'b0;
         o_qea_qbit_num   <= '0;
         o_qea_ctx_en     <= 1'b0;
         o_qea_ctx_wea    <= 1'b0;
         o_qea_ctx_addr   <= '0;
         o_qea_ctx_data   <= '0;
         o_qea_state_ena  <= '0;
         o_qea_state_wea  <= '0;
         o_qea_state_addr <= '0;
         o_qea_state_din  <= '0;
         o_busy           <= 1'b0;
         o_exec_cycles    <= '0;
         o_done           <= 1'b0;
      end else begin
         // Single-cycle strobes default low.
         o_qea_ctx_en  <= 1'b0;
         o_qea_ctx_wea <= 1'b0;
         o_qea_start   <= 1'b0;
         o_done        <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (i_go) begin
                  o_qea_qbit_num <= i_qbit_num;
                  ins_last       <= i_ins_num - CTX_INC;
                  // depth-1 = 2^(qbit-2)-1, i.e. a mask of the low qbit-2 bits.
                  state_last     <= ~({STATE_ADDR_WIDTH{1'b1}} << (i_qbit_num - MAX_QBIT_WIDTH'(2)));
                  ctx_cnt        <= '0;
                  o_busy         <= 1'b1;
                  o_ctx_ready    <= 1'b1;
                  state          <= ST_LOAD_CTX;
               end
            end

            ST_LOAD_CTX: begin
               if (i_ctx_valid) begin
                  o_qea_ctx_en   <= 1'b1;
                  o_qea_ctx_wea  <= 1'b1;
                  o_qea_ctx_addr <= ctx_cnt;
                  o_qea_ctx_data <= i_ctx_data;
                  ctx_cnt        <= ctx_cnt + CTX_INC;
                  if (ctx_cnt == ins_last) begin
                     // First state write overlaps the last context write.
                     o_ctx_ready      <= 1'b0;
                     o_qea_state_ena  <= '1;
                     o_qea_state_wea  <= '1;
                     o_qea_state_addr <= '0;
                     o_qea_state_din  <= INIT_WORD;
                     state            <= ST_LOAD_STATE;
                  end
               end
            end

            ST_LOAD_STATE: begin
               o_qea_state_din <= '0;
               if (o_qea_state_addr == state_last) begin
                  o_qea_state_ena <= '0;
                  o_qea_state_wea <= '0;
                  o_qea_start     <= 1'b1;
                  state           <= ST_START;
               end else begin
                  o_qea_state_addr <= o_qea_state_addr + ST_INC;
               end
            end

            ST_START: begin
               o_exec_cycles <= '0;
               state         <= ST_RUN;
            end

            ST_RUN: begin
               // Counting includes the completion cycle itself.
               if (o_exec_cycles != '1) begin
                  o_exec_cycles <= o_exec_cycles + 32'd1;
               end
               if (i_qea_complete) begin
                  o_qea_state_ena  <= '1;
                  o_qea_state_wea  <= '0;
                  o_qea_state_addr <= '0;
                  state            <= ST_RD_ADDR;
               end
            end

            ST_RD_ADDR: begin
               o_qea_state_ena <= '0;
               state           <= ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
               if (rd_cap) begin
                  state <= ST_RD_OUT;
               end
            end

            ST_RD_OUT: begin
               if (o_rd_valid && i_rd_ready) begin
                  if (o_qea_state_addr == state_last) begin
                     o_done <= 1'b1;
                     o_busy <= 1'b0;
                     state  <= ST_DONE;
                  end else begin
                     o_qea_state_ena  <= '1;
                     o_qea_state_addr <= o_qea_state_addr + ST_INC;
                     state            <= ST_RD_ADDR;
                  end
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/qea_host_sequencer.md
Name: qea_host_sequencer

Overview:
- Host-side initiator for the QEA accelerator's load/run/readback interface.
- Streams a gate-context program into the QEA context RAM and writes the |0...0> initial state into state RAM.
- Pulses start, counts cycles until completion, then reads every state word back and returns it as a valid/ready stream.
- Sits between a host DMA/UART bridge and the QEA top; drives exactly the QEA ctx/state/start port set.

Parameters:
- PE_NUM, 4, processing elements; state word = PE_NUM lanes.
- DATA_WIDTH, 32, real/imag component width.
- STATE_DATA_WIDTH, DATA_WIDTH*2, one complex amplitude {re,im}.
- STATE_ADDR_WIDTH, 16, state RAM address width.
- GATE_CONTEXT_DATA_WIDTH, DATA_WIDTH*2, context word width.
- GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width.
- MAX_QBIT_WIDTH, 6, qubit-count field width.
- NUM_FRAC_BIT, 30, fixed-point fraction bits; 1.0 = 1<<NUM_FRAC_BIT.
- READ_LATENCY, 1, cycles from state address to valid o_state_dout (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_go  in  1  one-cycle request to run a job; ignored unless idle.
- i_qbit_num  in  MAX_QBIT_WIDTH  qubits (3..STATE_ADDR_WIDTH+2), sampled on i_go.
- i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  context words to load (>=1), sampled on i_go.
- i_ctx_valid  in  1  host context word valid.
- i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  host context word.
- o_ctx_ready  out  1  sequencer accepts context word.
- o_qea_start  out  1  to QEA i_start.
- o_qea_qbit_num  out  MAX_QBIT_WIDTH  to QEA i_qbit_num.
- o_qea_ctx_en / o_qea_ctx_wea  out  1 each  to QEA ctx port.
- o_qea_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  to QEA.
- o_qea_ctx_data  out  GATE_CONTEXT_DATA_WIDTH  to QEA.
- o_qea_state_ena / o_qea_state_wea  out  PE_NUM each  to QEA state port.
- o_qea_state_addr  out  STATE_ADDR_WIDTH  to QEA.
- o_qea_state_din  out  PE_NUM*STATE_DATA_WIDTH  to QEA.
- i_qea_complete  in  1  from QEA o_complete.
- i_qea_state_dout  in  PE_NUM*STATE_DATA_WIDTH  from QEA.
- o_rd_valid  out  1  readback word valid.
- o_rd_data  out  PE_NUM*STATE_DATA_WIDTH  readback word.
- i_rd_ready  in  1  host accepts readback word.
- o_busy  out  1  job in progress.
- o_exec_cycles  out  32  cycles from start pulse to complete.
- o_done  out  1  one-cycle pulse after last readback handshake.

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0; o_exec_cycles 0. Reset mid-job aborts immediately; QEA strobes deassert the next edge.
- States: IDLE -> LOAD_CTX -> LOAD_STATE -> START -> RUN -> RD_ADDR -> RD_WAIT -> RD_OUT -> (RD_ADDR | DONE) -> IDLE.
- IDLE: on i_go, latch qbit/ins_num, depth = 2^(qbit-2), set o_busy, go to LOAD_CTX.
- LOAD_CTX: o_ctx_ready=1. Each i_ctx_valid&o_ctx_ready writes one word next cycle: ctx_en=wea=1, addr=k (0..ins_num-1), data=word.
  - Word ins_num-1 transfers -> LOAD_STATE.
  - No-valid cycles leave en=0.
- LOAD_STATE: one write per cycle, addr 0..depth-1, ena=wea=all ones.
  - Addr 0 data: top lane (bits [PE_NUM*SDW-1 -: SDW]) re = 1<<NUM_FRAC_BIT, im 0; all other lanes 0.
  - Other addresses: all zero.
  - After addr depth-1 -> START.
- START: o_qea_start=1 for exactly one cycle; clear cycle counter.
- RUN: counter increments each cycle; exits on i_qea_complete=1. o_exec_cycles = cycles from the start cycle (exclusive) to the first complete cycle (inclusive). Counter saturates at 2^32-1.
- RD_ADDR: ena=all ones, wea=0, addr=j; one cycle.
- RD_WAIT: wait READ_LATENCY cycles, then capture i_qea_state_dout into o_rd_data.
- RD_OUT: o_rd_valid=1, data stable until i_rd_ready. On handshake, next j or DONE after j=depth-1.
- DONE: o_done=1 one cycle, o_busy=0, -> IDLE.
- i_go while busy: ignored.
- i_qea_complete outside RUN: ignored.
- Address counters never wrap within a job; widths must hold depth-1.
- o_qea_qbit_num is held at the latched value from i_go until the next i_go.

Decomposition:
- Shared package qea_pkg: FSM state encoding, fixed-point ONE constant, helper for lane slice offsets.
- Sub-module qea_rd_capture: latency delay line plus output holding register with valid/ready.

Test Plan:
- 5 qubits, ins_num=3, ctx words 1,2,3 back-to-back -> ctx writes at addr 0,1,2; state writes at addr 0..7; addr0 din = 64'h40000000_00000000 in top lane, rest 0.
- ctx_valid gapped every other cycle -> writes only on handshakes, addresses contiguous, no extra en pulses.
- QEA model asserts complete 100 cycles after start -> single start pulse; o_exec_cycles=100.
- Readback with i_rd_ready low 3 cycles per word, READ_LATENCY=2 -> 8 words in address order, data stable while stalled, o_done one cycle after 8th handshake.
- rst asserted during RUN -> all outputs 0 next edge; new i_go completes a full job normally.
- i_go pulsed during LOAD_STATE -> ignored; latched qbit/ins_num unchanged.
